// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset control unit: a Moore/Mealy FSM that sequences fetch,
// decode, execute, memory and write-back, holding in memory states until mem_ready.
module multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    input  logic       zero,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       branch_ne,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic [3:0] alu_op,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        REXEC  = 4'd6,
        RWB    = 4'd7,
        BRANCH = 4'd8,
        IEXEC  = 4'd9,
        IWB    = 4'd10,
        JUMP   = 4'd11
    } state_e;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LUI  = 6'b001111;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [3:0] ALU_R   = 4'b1111;
    localparam logic [3:0] ALU_ADD = 4'b0100;
    localparam logic [3:0] ALU_ORI = 4'b0101;
    localparam logic [3:0] ALU_LUI = 4'b0110;
    localparam logic [3:0] ALU_LW  = 4'b0001;
    localparam logic [3:0] ALU_SW  = 4'b0010;
    localparam logic [3:0] ALU_BR  = 4'b0011;

    state_e state_q, state_d;

    // The zero flag is combined with pc_write_cond/branch_ne in the datapath.
    logic unused_zero;
    assign unused_zero = zero;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    assign state = state_q;

    always_comb begin
        state_d       = FETCH;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_ne     = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        pc_source     = 2'b00;
        alu_op        = 4'b0000;
        illegal_op    = 1'b0;

        case (state_q)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                alu_op    = ALU_ADD;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = DECODE;
                end else begin
                    state_d  = FETCH;
                end
            end
            DECODE: begin
                alu_src_b = 2'b11;
                alu_op    = ALU_ADD;
                case (opcode)
                    OP_LW, OP_SW:            state_d = MEMADR;
                    OP_R:                    state_d = REXEC;
                    OP_BEQ, OP_BNE:          state_d = BRANCH;
                    OP_ADDI, OP_ORI, OP_LUI: state_d = IEXEC;
                    OP_J:                    state_d = JUMP;
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                if (opcode == OP_SW) begin
                    alu_op  = ALU_SW;
                    state_d = MEMWR;
                end else begin
                    alu_op  = ALU_LW;
                    state_d = MEMRD;
                end
            end
            MEMRD: begin
                i_or_d   = 1'b1;
                mem_read = 1'b1;
                state_d  = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            MEMWR: begin
                i_or_d    = 1'b1;
                mem_write = 1'b1;
                state_d   = mem_ready ? FETCH : MEMWR;
            end
            REXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_R;
                state_d   = RWB;
            end
            RWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_BR;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                branch_ne     = (opcode == OP_BNE);
            end
            IEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = IWB;
                case (opcode)
                    OP_ADDI: alu_op = ALU_ADD;
                    OP_ORI:  alu_op = ALU_ORI;
                    OP_LUI:  alu_op = ALU_LUI;
                    default: alu_op = 4'b0000;
                endcase
            end
            IWB: begin
                reg_write = 1'b1;
            end
            JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            default: state_d = FETCH;
        endcase

        // Strobes must be quiet while reset is held, even though state_q already reads FETCH.
        if (reset) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            branch_ne     = 1'b0;
            i_or_d        = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            reg_dst       = 1'b0;
            mem_to_reg    = 1'b0;
            reg_write     = 1'b0;
            alu_src_a     = 1'b0;
            alu_src_b     = 2'b00;
            pc_source     = 2'b00;
            alu_op        = 4'b0000;
            illegal_op    = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class cycle by
// cycle and compares state plus a packed control word against hand-written values.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       zero;
    logic       pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write;
    logic       ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, pc_source;
    logic [3:0] alu_op, state;

    int total = 0;
    int bad   = 0;

    multicycle_control dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .zero          (zero),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .branch_ne     (branch_ne),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .pc_source     (pc_source),
        .alu_op        (alu_op),
        .illegal_op    (illegal_op),
        .state         (state)
    );

    always #5 clk = ~clk;

    logic [19:0] ctrl;
    assign ctrl = {pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write,
                   ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
                   alu_src_b, pc_source, alu_op, illegal_op};

    localparam logic [19:0] PCW = 20'h1 << 19;
    localparam logic [19:0] PWC = 20'h1 << 18;
    localparam logic [19:0] BNE = 20'h1 << 17;
    localparam logic [19:0] IOD = 20'h1 << 16;
    localparam logic [19:0] MR  = 20'h1 << 15;
    localparam logic [19:0] MW  = 20'h1 << 14;
    localparam logic [19:0] IRW = 20'h1 << 13;
    localparam logic [19:0] RD  = 20'h1 << 12;
    localparam logic [19:0] M2R = 20'h1 << 11;
    localparam logic [19:0] RW  = 20'h1 << 10;
    localparam logic [19:0] SA  = 20'h1 << 9;
    localparam logic [19:0] ILL = 20'h1;

    localparam logic [19:0] SB1 = 20'd1 << 7;
    localparam logic [19:0] SB2 = 20'd2 << 7;
    localparam logic [19:0] SB3 = 20'd3 << 7;
    localparam logic [19:0] PS1 = 20'd1 << 5;
    localparam logic [19:0] PS2 = 20'd2 << 5;
    localparam logic [19:0] OP1 = 20'd1 << 1;
    localparam logic [19:0] OP2 = 20'd2 << 1;
    localparam logic [19:0] OP3 = 20'd3 << 1;
    localparam logic [19:0] OP4 = 20'd4 << 1;
    localparam logic [19:0] OP5 = 20'd5 << 1;
    localparam logic [19:0] OP6 = 20'd6 << 1;
    localparam logic [19:0] OPF = 20'd15 << 1;

    localparam logic [19:0] C_FWAIT  = MR | SB1 | OP4;
    localparam logic [19:0] C_FRDY   = MR | SB1 | OP4 | IRW | PCW;
    localparam logic [19:0] C_DEC    = SB3 | OP4;
    localparam logic [19:0] C_DECILL = SB3 | OP4 | ILL;
    localparam logic [19:0] C_MALW   = SA | SB2 | OP1;
    localparam logic [19:0] C_MASW   = SA | SB2 | OP2;
    localparam logic [19:0] C_MEMRD  = IOD | MR;
    localparam logic [19:0] C_MEMWB  = RW | M2R;
    localparam logic [19:0] C_MEMWR  = IOD | MW;
    localparam logic [19:0] C_REXEC  = SA | OPF;
    localparam logic [19:0] C_RWB    = RW | RD;
    localparam logic [19:0] C_BEQ    = SA | OP3 | PWC | PS1;
    localparam logic [19:0] C_BNE    = SA | OP3 | PWC | PS1 | BNE;
    localparam logic [19:0] C_ADDI   = SA | SB2 | OP4;
    localparam logic [19:0] C_ORI    = SA | SB2 | OP5;
    localparam logic [19:0] C_LUI    = SA | SB2 | OP6;
    localparam logic [19:0] C_IWB    = RW;
    localparam logic [19:0] C_JUMP   = PCW | PS2;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // One clock of an instruction: drive mem_ready, check state and controls, advance.
    task automatic cyc(input string tag, input logic [3:0] exp_st, input logic [19:0] exp_ctrl,
                       input logic mr);
        mem_ready = mr;
        #1;
        check_val({tag, "/state"}, {28'd0, state}, {28'd0, exp_st});
        check_val({tag, "/ctrl"},  {12'd0, ctrl},  {12'd0, exp_ctrl});
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        opcode    = 6'b000000;
        mem_ready = 1'b1;
        zero      = 1'b0;
        #3;
        check_val("rst/state", {28'd0, state}, 32'd0);
        check_val("rst/ctrl",  {12'd0, ctrl},  32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // LW, no wait states: 0,1,2,3,4
        opcode = 6'b100011;
        cyc("lw_f",   4'd0, C_FRDY,  1'b1);
        cyc("lw_d",   4'd1, C_DEC,   1'b1);
        cyc("lw_ma",  4'd2, C_MALW,  1'b1);
        cyc("lw_rd",  4'd3, C_MEMRD, 1'b1);
        cyc("lw_wb",  4'd4, C_MEMWB, 1'b1);

        // R-type with three fetch wait states
        opcode = 6'b000000;
        cyc("r_fw1",  4'd0, C_FWAIT, 1'b0);
        cyc("r_fw2",  4'd0, C_FWAIT, 1'b0);
        cyc("r_fw3",  4'd0, C_FWAIT, 1'b0);
        cyc("r_f",    4'd0, C_FRDY,  1'b1);
        cyc("r_d",    4'd1, C_DEC,   1'b1);
        cyc("r_ex",   4'd6, C_REXEC, 1'b1);
        cyc("r_wb",   4'd7, C_RWB,   1'b1);

        // BNE then BEQ
        opcode = 6'b000101;
        cyc("bne_f",  4'd0, C_FRDY,  1'b1);
        cyc("bne_d",  4'd1, C_DEC,   1'b0);
        cyc("bne_br", 4'd8, C_BNE,   1'b1);
        opcode = 6'b000100;
        cyc("beq_f",  4'd0, C_FRDY,  1'b1);
        cyc("beq_d",  4'd1, C_DEC,   1'b1);
        cyc("beq_br", 4'd8, C_BEQ,   1'b0);

        // SW with two write wait states
        opcode = 6'b101011;
        cyc("sw_f",   4'd0, C_FRDY,  1'b1);
        cyc("sw_d",   4'd1, C_DEC,   1'b1);
        cyc("sw_ma",  4'd2, C_MASW,  1'b1);
        cyc("sw_w1",  4'd5, C_MEMWR, 1'b0);
        cyc("sw_w2",  4'd5, C_MEMWR, 1'b0);
        cyc("sw_w3",  4'd5, C_MEMWR, 1'b1);

        // Illegal opcode: one-cycle pulse, straight back to FETCH
        opcode = 6'b111111;
        cyc("ill_f",  4'd0, C_FRDY,   1'b1);
        cyc("ill_d",  4'd1, C_DECILL, 1'b1);

        // ORI, LUI, J, ADDI back to back
        opcode = 6'b001101;
        cyc("ori_f",  4'd0, C_FRDY,  1'b1);
        cyc("ori_d",  4'd1, C_DEC,   1'b1);
        cyc("ori_ex", 4'd9, C_ORI,   1'b1);
        cyc("ori_wb", 4'd10, C_IWB,  1'b1);
        opcode = 6'b001111;
        cyc("lui_f",  4'd0, C_FRDY,  1'b1);
        cyc("lui_d",  4'd1, C_DEC,   1'b1);
        cyc("lui_ex", 4'd9, C_LUI,   1'b1);
        cyc("lui_wb", 4'd10, C_IWB,  1'b1);
        opcode = 6'b000010;
        cyc("j_f",    4'd0, C_FRDY,  1'b1);
        cyc("j_d",    4'd1, C_DEC,   1'b1);
        cyc("j_jmp",  4'd11, C_JUMP, 1'b1);
        opcode = 6'b001000;
        cyc("addi_f",  4'd0, C_FRDY, 1'b1);
        cyc("addi_d",  4'd1, C_DEC,  1'b1);
        cyc("addi_ex", 4'd9, C_ADDI, 1'b1);
        cyc("addi_wb", 4'd10, C_IWB, 1'b1);

        // Reset between edges while waiting in MEMRD
        opcode = 6'b100011;
        cyc("lw2_f",  4'd0, C_FRDY,  1'b1);
        cyc("lw2_d",  4'd1, C_DEC,   1'b1);
        cyc("lw2_ma", 4'd2, C_MALW,  1'b1);
        cyc("lw2_rd", 4'd3, C_MEMRD, 1'b0);
        mem_ready = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_val("midrst/state", {28'd0, state}, 32'd0);
        check_val("midrst/ctrl",  {12'd0, ctrl},  32'd0);
        @(posedge clk);
        #1;
        check_val("holdrst/state", {28'd0, state}, 32'd0);
        check_val("holdrst/ctrl",  {12'd0, ctrl},  32'd0);
        reset  = 1'b0;
        opcode = 6'b001000;
        cyc("post_fw", 4'd0, C_FWAIT, 1'b0);
        cyc("post_f",  4'd0, C_FRDY,  1'b1);
        cyc("post_d",  4'd1, C_DEC,   1'b1);
        cyc("post_ex", 4'd9, C_ADDI,  1'b1);
        cyc("post_wb", 4'd10, C_IWB,  1'b1);
        cyc("end_f",   4'd0, C_FWAIT, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports as listed below.
REQ-002 clk  in  1  rising-edge clock
REQ-003 reset  in  1  asynchronous active-high reset
REQ-004 opcode  in  6  instruction bits [31:26] from the instruction register
REQ-005 mem_ready  in  1  memory completes the current read or write in this cycle
REQ-006 zero  in  1  ALU zero flag
REQ-007 pc_write  out  1  unconditional PC load
REQ-008 pc_write_cond  out  1  PC load if branch condition holds
REQ-009 branch_ne  out  1  branch condition is !zero (0 means zero)
REQ-010 i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
REQ-011 mem_read / mem_write  out  1 each  memory strobes
REQ-012 ir_write  out  1  instruction register load
REQ-013 reg_dst  out  1  write register select: 0 = rt, 1 = rd
REQ-014 mem_to_reg  out  1  write-back data select: 0 = ALUOut, 1 = MDR
REQ-015 reg_write  out  1  register file write enable
REQ-016 alu_src_a  out  1  ALU A select: 0 = PC, 1 = register A
REQ-017 alu_src_b  out  2  ALU B select: 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left by 2
REQ-018 pc_source  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
REQ-019 alu_op  out  4  code to the ALU control block
REQ-020 illegal_op  out  1  one-cycle pulse on an unsupported opcode
REQ-021 state  out  4  current state, for debug

Function
REQ-022 Recognised opcodes SHALL be:
- R = 000000
- LW = 100011
- SW = 101011
- BEQ = 000100
- BNE = 000101
- ADDI = 001000
- ORI = 001101
- LUI = 001111
- J = 000010
REQ-023 The alu_op encodings SHALL be: R = 1111, ADD = 0100, ORI = 0101, LUI = 0110, LW = 0001, SW = 0010, BRANCH = 0011.
REQ-024 The state encodings SHALL be:
- FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5
- REXEC = 6, RWB = 7, BRANCH = 8, IEXEC = 9, IWB = 10, JUMP = 11
REQ-025 The block SHALL register only the state; all outputs SHALL be decoded combinationally from the state and the inputs.
REQ-026 Any output not listed for a state SHALL be 0.
REQ-027 FETCH: i_or_d = 0, mem_read = 1, alu_src_a = 0, alu_src_b = 01, alu_op = 0100, pc_source = 00.
REQ-028 FETCH: ir_write and pc_write SHALL be 1 only in the cycle where mem_ready = 1; the state then goes to DECODE, otherwise it stays in FETCH.
REQ-029 DECODE: alu_src_a = 0, alu_src_b = 11, alu_op = 0100 (precomputes the branch target). Next state by opcode:
- LW or SW -> MEMADR
- R -> REXEC
- BEQ or BNE -> BRANCH
- ADDI, ORI or LUI -> IEXEC
- J -> JUMP
- any other opcode -> FETCH, with illegal_op = 1 for that cycle
REQ-030 MEMADR: alu_src_a = 1, alu_src_b = 10; alu_op = 0001 for LW or 0010 for SW. Next state is MEMRD for LW, MEMWR for SW.
REQ-031 MEMRD: i_or_d = 1, mem_read = 1; go to MEMWB when mem_ready = 1, otherwise stay.
REQ-032 MEMWB: reg_write = 1, mem_to_reg = 1, reg_dst = 0; go to FETCH.
REQ-033 MEMWR: i_or_d = 1, mem_write = 1; go to FETCH when mem_ready = 1, otherwise stay.
REQ-034 REXEC: alu_src_a = 1, alu_src_b = 00, alu_op = 1111; go to RWB.
REQ-035 RWB: reg_write = 1, reg_dst = 1, mem_to_reg = 0; go to FETCH.
REQ-036 BRANCH: alu_src_a = 1, alu_src_b = 00, alu_op = 0011, pc_write_cond = 1, pc_source = 01, branch_ne = 1 for BNE; go to FETCH.
REQ-037 IEXEC: alu_src_a = 1, alu_src_b = 10; alu_op = 0100 for ADDI, 0101 for ORI, 0110 for LUI; go to IWB.
REQ-038 IWB: reg_write = 1, reg_dst = 0, mem_to_reg = 0; go to FETCH.
REQ-039 JUMP: pc_write = 1, pc_source = 10; go to FETCH.
REQ-040 In MEMADR, IEXEC and BRANCH, the opcode SHALL be read from the instruction register, which is held stable because ir_write = 0 outside FETCH.
REQ-041 A mem_ready pulse outside FETCH, MEMRD and MEMWR SHALL be ignored.
REQ-042 There SHALL be no limit on wait states; the block stays in a memory state for as long as mem_ready = 0.
REQ-043 An unreachable state encoding (12 to 15) SHALL go to FETCH on the next clock.
REQ-044 Cycle counts with mem_ready = 1 on first request SHALL be: R, ADDI, ORI and LUI = 4; LW = 5; SW = 4; BEQ, BNE and J = 3.

Reset
REQ-045 Asserting reset SHALL force the state to FETCH immediately, without waiting for a clock edge, including in the middle of an instruction.
REQ-046 While reset is high, all outputs SHALL be 0 except state = 0.
REQ-047 The first FETCH strobes SHALL appear in the first cycle after reset deasserts.
REQ-048 An instruction interrupted by reset SHALL NOT be resumed.

Verification
REQ-049 Reset asserted in MEMRD between clock edges -> state = 0 at once; mem_read = 0 while reset is high.
REQ-050 LW with mem_ready = 1 always -> state sequence 0,1,2,3,4,0; exactly one reg_write pulse with mem_to_reg = 1; alu_op = 0001 in MEMADR.
REQ-051 R-type with mem_ready held 0 for 3 cycles in FETCH -> FETCH lasts 4 cycles; ir_write and pc_write are 1 only in the 4th; then states 1,6,7; reg_dst = 1.
REQ-052 BNE -> BRANCH with pc_write_cond = 1, branch_ne = 1, alu_op = 0011; SW with 2 wait states -> MEMWR lasts 3 cycles, with mem_write = 1 throughout.
REQ-053 opcode = 111111 -> DECODE pulses illegal_op = 1 for one cycle, next state = FETCH, and no reg_write or mem_write occurs.
REQ-054 ORI, then LUI, then J back-to-back -> alu_op = 0101 and 0110 in IEXEC; JUMP with pc_source = 10 and pc_write = 1; totals of 4, 4 and 3 cycles.
